// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a 5-stage in-order pipeline.
// Resolves data-memory back-pressure, taken branches, load-use hazards and
// instruction-fetch gaps into stall/flush/freeze controls. It also keeps
// saturating stall/flush performance counters and a sticky dmem timeout flag.
module pipeline_hazard_controller #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           rs1_ID,
  input  logic [3:0]           rs2_ID,
  input  logic                 uses_rs1_ID,
  input  logic                 uses_rs2_ID,
  input  logic [3:0]           rd_EX,
  input  logic                 mem_read_EX,
  input  logic                 branch_taken_EX,
  input  logic                 dmem_busy,
  input  logic                 imem_valid,
  output logic                 stall,
  output logic                 invalid_IF,
  output logic                 pc_write_en,
  output logic                 pc_redirect,
  output logic                 bubble_ID_EX,
  output logic                 freeze_back,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  // The wait counter has to hold values up to TIMEOUT_CYCLES inclusive.
  localparam int WAIT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0]    WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0]    WAIT_ONE = WAIT_W'(1);
  localparam logic [WAIT_W-1:0]    WAIT_ZERO = WAIT_W'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONES = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FREEZE = 2'b01,
    ST_ERROR  = 2'b10
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [WAIT_W-1:0]     wait_r;
  logic [WAIT_W-1:0]     wait_nxt_s;
  logic                  set_err_s;
  logic                  timeout_err_r;
  logic                  load_use_s;
  logic [CNT_WIDTH-1:0]  stall_cycles_r;
  logic [CNT_WIDTH-1:0]  flush_count_r;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use_s = mem_read_EX && (rd_EX != 4'd0) &&
                      ((uses_rs1_ID && (rs1_ID == rd_EX)) ||
                       (uses_rs2_ID && (rs2_ID == rd_EX)));

  // State register and dmem wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      wait_r  <= WAIT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      wait_r  <= wait_nxt_s;
    end
  end

  // Next-state logic: FREEZE counts busy cycles, ERROR is only left through reset.
  always_comb begin
    state_nxt_s = state_r;
    wait_nxt_s  = wait_r;
    set_err_s   = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (dmem_busy) begin
          state_nxt_s = ST_FREEZE;
          wait_nxt_s  = WAIT_ONE;
        end else begin
          state_nxt_s = ST_RUN;
          wait_nxt_s  = WAIT_ZERO;
        end
      end
      ST_FREEZE: begin
        if (dmem_busy) begin
          if (wait_r == WAIT_MAX) begin
            state_nxt_s = ST_ERROR;
            set_err_s   = 1'b1;
          end else begin
            wait_nxt_s  = wait_r + WAIT_ONE;
          end
        end else begin
          state_nxt_s = ST_RUN;
          wait_nxt_s  = WAIT_ZERO;
        end
      end
      ST_ERROR: begin
        state_nxt_s = ST_ERROR;
      end
      default: begin
        state_nxt_s = ST_RUN;
        wait_nxt_s  = WAIT_ZERO;
      end
    endcase
  end

  // Hazard outputs. A non-busy FREEZE cycle is resolved exactly like RUN.
  always_comb begin
    stall        = 1'b0;
    invalid_IF   = 1'b0;
    pc_write_en  = 1'b0;
    pc_redirect  = 1'b0;
    bubble_ID_EX = 1'b0;
    freeze_back  = 1'b0;
    if (!rst_n) begin
      invalid_IF   = 1'b1;
      bubble_ID_EX = 1'b1;
    end else begin
      case (state_r)
        ST_RUN, ST_FREEZE: begin
          if (dmem_busy) begin
            stall       = 1'b1;
            freeze_back = 1'b1;
          end else if (branch_taken_EX) begin
            invalid_IF   = 1'b1;
            bubble_ID_EX = 1'b1;
            pc_redirect  = 1'b1;
            pc_write_en  = 1'b1;
          end else if (load_use_s) begin
            stall        = 1'b1;
            bubble_ID_EX = 1'b1;
          end else if (!imem_valid) begin
            invalid_IF   = 1'b1;
          end else begin
            pc_write_en  = 1'b1;
          end
        end
        ST_ERROR: begin
          stall       = 1'b1;
          freeze_back = 1'b1;
        end
        default: begin
          stall       = 1'b1;
          freeze_back = 1'b1;
        end
      endcase
    end
  end

  // Sticky timeout flag, set on the transition into ERROR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err_r <= 1'b0;
    end else if (set_err_s) begin
      timeout_err_r <= 1'b1;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

  // Saturating performance counters for stall cycles and branch flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_r <= CNT_ZERO;
      flush_count_r  <= CNT_ZERO;
    end else begin
      if (stall && (stall_cycles_r != CNT_ONES)) begin
        stall_cycles_r <= stall_cycles_r + CNT_ONE;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (pc_redirect && (flush_count_r != CNT_ONES)) begin
        flush_count_r <= flush_count_r + CNT_ONE;
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign timeout_err  = timeout_err_r;
  assign stall_cycles = stall_cycles_r;
  assign flush_count  = flush_count_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios with
// literal expectations plus constrained-random traffic compared every cycle
// against a table-driven behavioural model.
module tb_pipeline_hazard_controller;

  localparam int TMO = 4;
  localparam int CW  = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  // Output vector order: {stall, invalid_IF, pc_write_en, pc_redirect, bubble_ID_EX, freeze_back, timeout_err}
  localparam logic [6:0] V_RESET  = 7'b0100100;
  localparam logic [6:0] V_NONE   = 7'b0010000;
  localparam logic [6:0] V_BUSY   = 7'b1000010;
  localparam logic [6:0] V_BRANCH = 7'b0111100;
  localparam logic [6:0] V_LDUSE  = 7'b1000100;
  localparam logic [6:0] V_NOIMEM = 7'b0100000;
  localparam logic [6:0] V_ERROR  = 7'b1000011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] rs1_ID = 4'd0, rs2_ID = 4'd0, rd_EX = 4'd0;
  logic uses_rs1_ID = 1'b0, uses_rs2_ID = 1'b0, mem_read_EX = 1'b0;
  logic branch_taken_EX = 1'b0, dmem_busy = 1'b0, imem_valid = 1'b1;
  logic stall, invalid_IF, pc_write_en, pc_redirect, bubble_ID_EX, freeze_back, timeout_err;
  logic [CW-1:0] stall_cycles, flush_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model state: count of consecutive busy cycles, dead after timeout, counters.
  bit m_dead = 1'b0;
  int m_busy_run = 0;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;

  pipeline_hazard_controller #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
    .rd_EX(rd_EX), .mem_read_EX(mem_read_EX),
    .branch_taken_EX(branch_taken_EX), .dmem_busy(dmem_busy), .imem_valid(imem_valid),
    .stall(stall), .invalid_IF(invalid_IF), .pc_write_en(pc_write_en),
    .pc_redirect(pc_redirect), .bubble_ID_EX(bubble_ID_EX), .freeze_back(freeze_back),
    .timeout_err(timeout_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] dut_vec();
    return {stall, invalid_IF, pc_write_en, pc_redirect, bubble_ID_EX, freeze_back, timeout_err};
  endfunction

  function automatic bit hazard_lu();
    return mem_read_EX && (rd_EX != 4'd0) &&
           ((uses_rs1_ID && rs1_ID == rd_EX) || (uses_rs2_ID && rs2_ID == rd_EX));
  endfunction

  // Priority table: reset, dead, busy, branch, load-use, fetch gap, normal.
  function automatic logic [6:0] model_out();
    if (!rst_n) return V_RESET;
    if (m_dead) return V_ERROR;
    if (dmem_busy) return V_BUSY;
    if (branch_taken_EX) return V_BRANCH;
    if (hazard_lu()) return V_LDUSE;
    if (!imem_valid) return V_NOIMEM;
    return V_NONE;
  endfunction

  // Model advance on each clock edge; reset clears everything immediately.
  always @(posedge clk or negedge rst_n) begin
    logic [6:0] o;
    if (!rst_n) begin
      m_dead = 1'b0; m_busy_run = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      o = model_out();
      if (o[6] && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if (o[3] && m_flush_cnt < CNT_MAX) m_flush_cnt++;
      if (!m_dead) begin
        if (dmem_busy) begin
          m_busy_run++;
          if (m_busy_run == TMO + 1) m_dead = 1'b1;
        end else begin
          m_busy_run = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("outputs", {25'd0, dut_vec()}, {25'd0, model_out()});
    chk("stall_cycles", {24'd0, stall_cycles}, m_stall_cnt);
    chk("flush_count", {24'd0, flush_count}, m_flush_cnt);
  end

  task automatic idle();
    rs1_ID = 4'd0; rs2_ID = 4'd0; rd_EX = 4'd0;
    uses_rs1_ID = 1'b0; uses_rs2_ID = 1'b0; mem_read_EX = 1'b0;
    branch_taken_EX = 1'b0; dmem_busy = 1'b0; imem_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0; idle();
    @(negedge clk);
    chk("reset_vec", {25'd0, dut_vec()}, {25'd0, V_RESET});
    chk("reset_cnts", {16'd0, stall_cycles, flush_count}, 32'd0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    bit busy_prev;
    idle();
    do_reset();

    // Load-use on rs2 stalls exactly one cycle.
    mem_read_EX = 1'b1; rd_EX = 4'd5; rs2_ID = 4'd5; uses_rs2_ID = 1'b1;
    @(negedge clk); chk("lu_vec", {25'd0, dut_vec()}, {25'd0, 7'b1000100});
    step(); idle();
    @(negedge clk); chk("lu_after", {25'd0, dut_vec()}, {25'd0, 7'b0010000});
    chk("lu_stall_cnt", {24'd0, stall_cycles}, 32'd1);

    // A load to x0 is never a hazard.
    do_reset();
    mem_read_EX = 1'b1; rd_EX = 4'd0; rs1_ID = 4'd0; uses_rs1_ID = 1'b1;
    @(negedge clk); chk("x0_vec", {25'd0, dut_vec()}, {25'd0, 7'b0010000});

    // Branch beats load-use.
    do_reset();
    mem_read_EX = 1'b1; rd_EX = 4'd7; rs1_ID = 4'd7; uses_rs1_ID = 1'b1; branch_taken_EX = 1'b1;
    @(negedge clk); chk("br_vec", {25'd0, dut_vec()}, {25'd0, 7'b0111100});
    step(); idle();
    @(negedge clk); chk("br_cnts", {16'd0, stall_cycles, flush_count}, {16'd0, 8'd0, 8'd1});

    // Fetch gap only.
    imem_valid = 1'b0;
    @(negedge clk); chk("noimem_vec", {25'd0, dut_vec()}, {25'd0, 7'b0100000});

    // Branch held across three busy cycles is acted on in cycle four.
    do_reset();
    dmem_busy = 1'b1; branch_taken_EX = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("busy_br_vec", {25'd0, dut_vec()}, {25'd0, 7'b1000010});
      step();
    end
    dmem_busy = 1'b0;
    @(negedge clk); chk("busy_br_redirect", {25'd0, dut_vec()}, {25'd0, 7'b0111100});
    step(); idle();
    @(negedge clk); chk("busy_br_cnts", {16'd0, stall_cycles, flush_count}, {16'd0, 8'd3, 8'd1});

    // Timeout: five busy cycles with TIMEOUT_CYCLES=4 lands in ERROR.
    do_reset();
    dmem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("tmo_busy_vec", {25'd0, dut_vec()}, {25'd0, 7'b1000010});
      step();
    end
    dmem_busy = 1'b0;
    @(negedge clk); chk("tmo_err_vec", {25'd0, dut_vec()}, {25'd0, 7'b1000011});
    // ERROR persists and keeps counting stalls until saturation.
    repeat (260) step();
    @(negedge clk); chk("tmo_err_held", {25'd0, dut_vec()}, {25'd0, 7'b1000011});
    chk("stall_sat", {24'd0, stall_cycles}, 32'd255);

    // Reset pulse mid-FREEZE abandons the wait.
    do_reset();
    dmem_busy = 1'b1;
    step(); step();
    rst_n = 1'b0;
    #1 chk("mid_freeze_rst", {25'd0, dut_vec()}, {25'd0, 7'b0100100});
    chk("mid_freeze_cnts", {16'd0, stall_cycles, flush_count}, 32'd0);
    step();
    rst_n = 1'b1; idle();
    @(negedge clk); chk("after_rst_run", {25'd0, dut_vec()}, {25'd0, 7'b0010000});

    // Random traffic, busy in bursts so timeouts occur occasionally.
    busy_prev = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      step();
      rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      rs1_ID = 4'($urandom_range(0, 3));
      rs2_ID = 4'($urandom_range(0, 3));
      rd_EX = 4'($urandom_range(0, 3));
      uses_rs1_ID = 1'($urandom_range(0, 1));
      uses_rs2_ID = 1'($urandom_range(0, 1));
      mem_read_EX = 1'($urandom_range(0, 1));
      branch_taken_EX = ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0;
      imem_valid = ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0;
      dmem_busy = busy_prev ? (($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0)
                            : (($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0);
      busy_prev = dmem_busy;
    end
    step(); rst_n = 1'b1; idle();
    @(negedge clk); #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
